// File: rtl/wind_profile_sched_pkg.sv
// Shared widths, default wind profile constants and FSM encoding for the wind scheduler.
package wind_profile_sched_pkg;

    localparam int WIDTH_TIME = 32;
    localparam int SINGLE     = 32;

    localparam logic [SINGLE-1:0]     WIND_DEF0 = 32'h411B3333;  // 9.7 m/s
    localparam logic [SINGLE-1:0]     WIND_DEF1 = 32'h41400000;  // 12 m/s
    localparam logic [SINGLE-1:0]     WIND_DEF2 = 32'h41600000;  // 14 m/s
    localparam logic [WIDTH_TIME-1:0] T_DEF0    = 32'd400000;
    localparam logic [WIDTH_TIME-1:0] T_DEF1    = 32'd800000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic [WIDTH_TIME-1:0] def_end(input int idx);
        case (idx)
            0:       def_end = T_DEF0;
            1:       def_end = T_DEF1;
            default: def_end = '0;
        endcase
    endfunction

    function automatic logic [SINGLE-1:0] def_speed(input int idx);
        case (idx)
            0:       def_speed = WIND_DEF0;
            1:       def_speed = WIND_DEF1;
            2:       def_speed = WIND_DEF2;
            default: def_speed = '0;
        endcase
    endfunction

endpackage

// File: rtl/wind_profile_sched_wind_seg_table.sv
// Segment table: synchronous write, asynchronous read, default profile on reset.
// Also holds the index of the final segment.
module wind_seg_table
    import wind_profile_sched_pkg::*;
#(
    parameter int NSEG = 4,
    parameter int AW   = $clog2(NSEG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH_TIME-1:0] wr_end,
    input  logic [SINGLE-1:0]     wr_speed,
    input  logic                  wr_last,
    input  logic [AW-1:0]         rd_idx,
    output logic [WIDTH_TIME-1:0] rd_end,
    output logic [SINGLE-1:0]     rd_speed_nxt,
    output logic [SINGLE-1:0]     speed0,
    output logic [AW-1:0]         last_idx
);

    localparam logic [AW-1:0] LAST_DEF = AW'((NSEG > 2) ? 2 : NSEG - 1);

    logic [WIDTH_TIME-1:0] end_q   [NSEG];
    logic [WIDTH_TIME-1:0] end_d   [NSEG];
    logic [SINGLE-1:0]     speed_q [NSEG];
    logic [SINGLE-1:0]     speed_d [NSEG];
    logic [AW-1:0]         last_q;
    logic [AW-1:0]         last_d;
    logic [AW-1:0]         nxt_idx;

    always_comb begin
        for (int i = 0; i < NSEG; i++) begin
            end_d[i]   = end_q[i];
            speed_d[i] = speed_q[i];
        end
        last_d = last_q;
        if (wr_en) begin
            end_d[wr_addr]   = wr_end;
            speed_d[wr_addr] = wr_speed;
            if (wr_last) begin
                last_d = wr_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEG; i++) begin
                end_q[i]   <= def_end(i);
                speed_q[i] <= def_speed(i);
            end
            last_q <= LAST_DEF;
        end else begin
            for (int i = 0; i < NSEG; i++) begin
                end_q[i]   <= end_d[i];
                speed_q[i] <= speed_d[i];
            end
            last_q <= last_d;
        end
    end

    assign nxt_idx      = rd_idx + AW'(1);
    assign rd_end       = end_q[rd_idx];
    assign rd_speed_nxt = speed_q[nxt_idx];
    assign speed0       = speed_q[0];
    assign last_idx     = last_q;

endmodule

// File: rtl/wind_profile_sched.sv
// Walks the wind segment table against sim_time and drives a registered VWind word.
// All outputs are registered one clock after the triggering input; no combinational in-to-out path.
module wind_profile_sched
    import wind_profile_sched_pkg::*;
#(
    parameter int NSEG = 4,
    parameter int AW   = $clog2(NSEG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH_TIME-1:0] sim_time,
    input  logic                  run,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [WIDTH_TIME-1:0] cfg_end_time,
    input  logic [SINGLE-1:0]     cfg_speed,
    input  logic                  cfg_last,
    output logic [SINGLE-1:0]     VWind,
    output logic                  vwind_upd,
    output logic [AW-1:0]         seg_idx,
    output logic                  cfg_err
);

    logic [0:0]            state_q, state_d;
    logic                  first_q, first_d;
    logic [WIDTH_TIME-1:0] prev_time_q, prev_time_d;
    logic [AW-1:0]         seg_idx_q, seg_idx_d;
    logic [SINGLE-1:0]     vwind_q, vwind_d;
    logic                  upd_q, upd_d;
    logic                  err_q, err_d;

    logic [WIDTH_TIME-1:0] cur_end;
    logic [SINGLE-1:0]     nxt_speed;
    logic [SINGLE-1:0]     speed0;
    logic [AW-1:0]         last_idx;

    wind_seg_table #(
        .NSEG (NSEG),
        .AW   (AW)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (cfg_we && (state_q == ST_IDLE)),
        .wr_addr      (cfg_addr),
        .wr_end       (cfg_end_time),
        .wr_speed     (cfg_speed),
        .wr_last      (cfg_last),
        .rd_idx       (seg_idx_q),
        .rd_end       (cur_end),
        .rd_speed_nxt (nxt_speed),
        .speed0       (speed0),
        .last_idx     (last_idx)
    );

    always_comb begin
        state_d     = state_q;
        first_d     = 1'b0;
        prev_time_d = sim_time;
        seg_idx_d   = seg_idx_q;
        vwind_d     = vwind_q;
        upd_d       = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Keep the active index inside the table if last_idx was rewritten lower.
                if (seg_idx_q > last_idx) begin
                    seg_idx_d = last_idx;
                end
                if (run) begin
                    state_d   = ST_RUN;
                    first_d   = 1'b1;
                    seg_idx_d = '0;
                    vwind_d   = speed0;
                    upd_d     = 1'b1;
                end
            end
            default: begin
                err_d = cfg_we;
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (!first_q && (sim_time < prev_time_q)) begin
                    seg_idx_d = '0;
                    vwind_d   = speed0;
                    upd_d     = 1'b1;
                end else if ((seg_idx_q < last_idx) && (sim_time > cur_end)) begin
                    seg_idx_d = seg_idx_q + AW'(1);
                    vwind_d   = nxt_speed;
                    upd_d     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            first_q     <= 1'b0;
            prev_time_q <= '0;
            seg_idx_q   <= '0;
            vwind_q     <= '0;
            upd_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            prev_time_q <= prev_time_d;
            seg_idx_q   <= seg_idx_d;
            vwind_q     <= vwind_d;
            upd_q       <= upd_d;
            err_q       <= err_d;
        end
    end

    assign VWind     = vwind_q;
    assign vwind_upd = upd_q;
    assign seg_idx   = seg_idx_q;
    assign cfg_err   = err_q;

endmodule

// File: doc/wind_profile_sched.md
# wind_profile_sched

Schedules the wind-speed stimulus for the wind-turbine real-time model. It replaces a fixed three-step wind generator with a programmable table of up to NSEG segments, each holding an end time and a single-precision speed. While running, it walks the table against `sim_time` and drives the registered `VWind` word consumed by the turbine aerodynamic datapath. Segments are written through a simple write port while the block is idle; reset preloads the standard 9.7 / 12 / 14 m/s profile.

## Interface
Parameters:
- `NSEG`, 4: table depth in segments, power of two, at least 2.
- `AW`, log2(NSEG): segment index width.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sim_time`, in, `WIDTH_TIME`: current simulation time-step count.
- `run`, in, 1: level signal; 1 means schedule, 0 means idle.
- `cfg_we`, in, 1: table write strobe.
- `cfg_addr`, in, AW: segment written.
- `cfg_end_time`, in, `WIDTH_TIME`: last `sim_time` value belonging to the segment (inclusive).
- `cfg_speed`, in, `SINGLE`: IEEE-754 single speed for the segment.
- `cfg_last`, in, 1: marks `cfg_addr` as the final segment.
- `VWind`, out, `SINGLE`: scheduled wind speed (registered).
- `vwind_upd`, out, 1: one-cycle pulse when `VWind` is loaded.
- `seg_idx`, out, AW: active segment.
- `cfg_err`, out, 1: one-cycle pulse when a write is rejected.

## Operation
Reset state:
- FSM is IDLE.
- `VWind`=0, `vwind_upd`=0, `seg_idx`=0, `cfg_err`=0.
- Table preload:
  - entry 0: end 400000, speed 32'h411B3333.
  - entry 1: end 800000, speed 32'h41400000.
  - entry 2: end don't-care, speed 32'h41600000.
  - remaining entries: 0.
- `last_idx`=2.

States:
- IDLE:
  - `cfg_we` writes the entry. If `cfg_last`=1, it also sets `last_idx`=`cfg_addr`.
  - `VWind` holds its value.
  - When `run`=1, go to RUN: `seg_idx`←0, `VWind`←speed[0], pulse `vwind_upd`.
- RUN, evaluated each cycle in this priority order:
  1. `run`=0: go to IDLE. `VWind` and `seg_idx` hold; no pulse.
  2. Restart: `sim_time` < `prev_time` (registered previous sample). Set `seg_idx`←0, `VWind`←speed[0], pulse `vwind_upd`.
  3. Advance: `seg_idx`≠`last_idx` and `sim_time` > end_time[`seg_idx`]. Set `seg_idx`+1, `VWind`←speed[`seg_idx`+1], pulse `vwind_upd`.
  4. Otherwise hold.
- In RUN, `cfg_we`=1 is ignored and pulses `cfg_err`. The table is unchanged.

Rules:
- Comparisons are unsigned over `WIDTH_TIME`. Speeds are passed through as opaque bits; the block does no float arithmetic.
- `sim_time` equal to end_time stays in the current segment, so segment boundaries are inclusive.
- The segment at `last_idx` holds indefinitely and its end_time is ignored.
- At most one advance per cycle. If `sim_time` jumps past several ends at once, the block steps one segment per clock until it catches up, pulsing each step.
- `prev_time` updates every cycle in all states. On entry to RUN, the restart test is suppressed for that first cycle.
- `seg_idx` never exceeds `last_idx`, even if `last_idx` is rewritten lower while idle; the RUN entry resets it to 0.

## Timing
- `VWind`, `seg_idx` and `vwind_upd` all change on the same edge, one clock after the triggering `sim_time` or `run` value is present at the input.
- Latency from a `sim_time` threshold crossing to `VWind` is 1 cycle.
- Latency from `run` rising to the first `VWind` is 1 cycle.
- A table write in IDLE is visible to a RUN entry on the very next cycle.
- Asserting `rst_n` mid-RUN immediately restores the reset state and the preloaded table. Runtime writes are lost.
- No combinational path from any input to any output.

## Structure
- Shared package / `global_parameter` holds:
  - `WIDTH_TIME` and `SINGLE`.
  - The default profile constants: WIND_DEF0..2 and T_DEF0..1.
  - The FSM state encoding.
- Sub-module `wind_seg_table`: NSEG-entry register file with synchronous write, asynchronous read, reset preload, and the `last_idx` register.
- The top level contains the FSM, `prev_time` and the comparators.

## Test plan
- Reset preload: reset, `run`=1, ramp `sim_time` 0→900000. Required: `VWind`=411B3333 until the cycle after 400001, then 41400000; 41600000 after 800001. Exactly 3 `vwind_upd` pulses.
- Boundary: `sim_time`=400000 exactly keeps `seg_idx`=0; 400001 gives `seg_idx`=1 one cycle later.
- Reprogram: in IDLE write 4 entries (ends 10/20/30, speeds A/B/C/D, `cfg_last` on addr 3), then run from 0 to 40. Required: `VWind` steps A→B→C→D at 11/21/31, and D holds.
- Multi-skip: jump `sim_time` 5→35 with the 4-entry table. Required: `seg_idx` goes 0→1→2→3 on 3 consecutive clocks with 3 pulses.
- Restart and reject: in RUN drop `sim_time` 500000→0. Required: `seg_idx`=0, `VWind`=speed[0], 1 pulse. A `cfg_we` during RUN gives a `cfg_err` pulse and the table is unchanged.
- Mid-run reset: assert `rst_n`=0 while `seg_idx`=2. Required: `VWind`=0, IDLE, table restored to defaults.
